npu_out_collector: RTL
======================

NPU_OUT_COLLECTOR -- requirements
Module: npu_out_collector

Interface
REQ-001 SHALL have parameter DWIDTH, default 16: width of one array column result.
REQ-002 SHALL have parameter SKEW, default 1: per-column lag in cycles between adjacent array columns (legal 1..4).
REQ-003 SHALL have parameter DEPTH, default 4: output FIFO entries (power of two, 2..16).
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port in_en, input, 1: array enable; column outputs valid this cycle.
REQ-007 SHALL have port col0, col1, col2, input, DWIDTH each: bottom-row PE down outputs, columns 0..2.
REQ-008 SHALL have port in_flush, input, 1: end-of-batch; invalidates deskew taps, clears row counter and overflow.
REQ-009 SHALL have port out_valid, output, 1: FIFO head holds a row.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts head when out_valid high.
REQ-011 SHALL have port out_data, output, 3*DWIDTH: {col2,col1,col0} aligned row at FIFO head.
REQ-012 SHALL have port out_row, output, 8: row index of head entry.
REQ-013 SHALL have port fifo_count, output, $clog2(DEPTH)+1: current occupancy.
REQ-014 SHALL have port overflow, output, 1: sticky; a row was dropped because FIFO full.

Function
REQ-015 Deskew: col0 delayed 2*SKEW cycles, col1 delayed SKEW cycles, col2 undelayed; aligned row at cycle t = {col2(t), col1(t-SKEW), col0(t-2*SKEW)}.
REQ-016 in_en SHALL be carried through the same delay taps; aligned row valid at t only if in_en high at t, t-SKEW and t-2*SKEW.
REQ-017 Valid aligned row SHALL push into FIFO at t's clock edge, tagged with row counter; row counter then increments, wrapping 255 -> 0.
REQ-018 Push with FIFO full and no simultaneous pop SHALL drop the row, set overflow, and not increment row counter.
REQ-019 Push and pop in same cycle when full SHALL both succeed; count unchanged.
REQ-020 Pop occurs when out_valid and out_ready both high; out_ready while empty SHALL have no effect.
REQ-021 FIFO is show-ahead: out_data/out_row reflect head while out_valid high; remain stable until popped.
REQ-022 Latency: row valid at edge t with FIFO empty -> out_valid high in cycle after edge t (1 cycle).
REQ-023 fifo_count SHALL equal pushes minus pops, range 0..DEPTH; out_valid == (fifo_count != 0).
REQ-024 in_flush (synchronous, one cycle) SHALL clear all delay-tap valid bits, row counter and overflow; FIFO contents and in-flight pop unaffected; a row that would become valid in the flush cycle SHALL be discarded.
REQ-025 Data arithmetic: none; values pass bit-exact, no truncation or sign change.
REQ-026 in_en low for one or more cycles mid-stream SHALL produce no row for any alignment window that includes a low sample; no stale data pushed.

Reset
REQ-027 rst_n low SHALL asynchronously clear: out_valid 0, out_data 0, out_row 0, fifo_count 0, overflow 0, row counter 0, all tap valid bits 0.
REQ-028 Reset asserted mid-operation SHALL discard FIFO contents and in-flight taps; first row after release indexed 0.
REQ-029 Deassertion of rst_n is synchronised externally; block SHALL accept pushes from first edge after release.

Verification
REQ-030 SKEW=1, out_ready=1, in_en high cycles 0..4, col0=10+c, col1=20+c, col2=30+c at cycle c -> rows at cycles 3,4,5: {32,21,10},{33,22,11},{34,23,12}, out_row 0,1,2.
REQ-031 out_ready=0, 6 valid rows, DEPTH=4 -> fifo_count saturates at 4, overflow=1, head out_row=0; then out_ready=1 -> rows 0..3 exit in order, no duplicates.
REQ-032 FIFO full, valid row and out_ready=1 same cycle -> pop row 0, push row 4, fifo_count stays 4, overflow stays 0.
REQ-033 in_en low at cycle 2 of a 0..6 burst (SKEW=1) -> rows whose window covers cycle 2 (aligned at t=2,3,4) absent; others present with consecutive out_row.
REQ-034 in_flush pulse with 2 rows queued -> overflow and row counter cleared, both queued rows still drain intact, next new row has out_row 0.
REQ-035 rst_n pulled low asynchronously between edges with 3 rows queued -> out_valid, fifo_count, overflow zero immediately, before next clk edge.

Source files
------------

// File: rtl/npu_out_collector.sv
// Output collector for a 3-column systolic array: deskews the bottom-row column
// outputs into aligned rows, tags each row with an index and queues it in a show-ahead FIFO.
module npu_out_collector #(
    parameter int DWIDTH = 16,
    parameter int SKEW   = 1,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_en,
    input  logic [DWIDTH-1:0]         col0,
    input  logic [DWIDTH-1:0]         col1,
    input  logic [DWIDTH-1:0]         col2,
    input  logic                      in_flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [3*DWIDTH-1:0]       out_data,
    output logic [7:0]                out_row,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int D0 = 2 * SKEW;
    localparam int D1 = SKEW;

    logic [DWIDTH-1:0]   c0_q [D0];
    logic [DWIDTH-1:0]   c0_d [D0];
    logic [DWIDTH-1:0]   c1_q [D1];
    logic [DWIDTH-1:0]   c1_d [D1];
    logic [D0-1:0]       v0_q;
    logic [D0-1:0]       v0_d;
    logic [D0-1:0]       v0_sh_s;
    logic [D1-1:0]       v1_q;
    logic [D1-1:0]       v1_d;
    logic [D1-1:0]       v1_sh_s;

    logic [3*DWIDTH-1:0] mem_data_q [DEPTH];
    logic [7:0]          mem_row_q  [DEPTH];
    logic [AW-1:0]       wr_ptr_q;
    logic [AW-1:0]       wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q;
    logic [AW-1:0]       rd_ptr_d;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       count_d;
    logic                out_valid_q;
    logic                out_valid_d;
    logic                overflow_q;
    logic                overflow_d;
    logic [7:0]          row_cnt_q;
    logic [7:0]          row_cnt_d;

    logic                row_vld_s;
    logic                push_req_s;
    logic                pop_s;
    logic                full_s;
    logic                push_ok_s;
    logic                drop_s;
    logic [3*DWIDTH-1:0] row_data_s;

    // Deskew tap next-state: shift data and enable through equal-length delay lines
    always_comb begin
        c0_d[0]    = col0;
        v0_sh_s    = '0;
        v0_sh_s[0] = in_en;
        for (int i = 1; i < D0; i++) begin
            c0_d[i]    = c0_q[i-1];
            v0_sh_s[i] = v0_q[i-1];
        end
        c1_d[0]    = col1;
        v1_sh_s    = '0;
        v1_sh_s[0] = in_en;
        for (int i = 1; i < D1; i++) begin
            c1_d[i]    = c1_q[i-1];
            v1_sh_s[i] = v1_q[i-1];
        end
        // Flush kills every in-flight enable sample, including this cycle's.
        v0_d = in_flush ? {D0{1'b0}} : v0_sh_s;
        v1_d = in_flush ? {D1{1'b0}} : v1_sh_s;
    end

    // Deskew tap registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D0; i++) begin
                c0_q[i] <= '0;
            end
            for (int i = 0; i < D1; i++) begin
                c1_q[i] <= '0;
            end
            v0_q <= '0;
            v1_q <= '0;
        end else begin
            c0_q <= c0_d;
            c1_q <= c1_d;
            v0_q <= v0_d;
            v1_q <= v1_d;
        end
    end

    assign row_vld_s  = in_en & v1_q[D1-1] & v0_q[D0-1];
    assign row_data_s = {col2, c1_q[D1-1], c0_q[D0-1]};
    assign push_req_s = row_vld_s & ~in_flush;
    assign pop_s      = out_valid_q & out_ready;
    assign full_s     = (count_q == CW'(DEPTH));
    assign push_ok_s  = push_req_s & (~full_s | pop_s);
    assign drop_s     = push_req_s & full_s & ~pop_s;

    // FIFO control next-state: pointers, occupancy, row tag counter and sticky overflow
    always_comb begin
        wr_ptr_d = push_ok_s ? (wr_ptr_q + AW'(1'b1)) : wr_ptr_q;
        rd_ptr_d = pop_s ? (rd_ptr_q + AW'(1'b1)) : rd_ptr_q;
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase
        out_valid_d = (count_d != CW'(1'b0));
        if (in_flush) begin
            overflow_d = 1'b0;
            row_cnt_d  = 8'd0;
        end else begin
            overflow_d = overflow_q | drop_s;
            row_cnt_d  = push_ok_s ? (row_cnt_q + 8'd1) : row_cnt_q;
        end
    end

    // FIFO control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            row_cnt_q   <= 8'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            row_cnt_q   <= row_cnt_d;
        end
    end

    // FIFO storage; cleared on reset so the head reads zero while empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_row_q[i]  <= 8'd0;
            end
        end else if (push_ok_s) begin
            mem_data_q[wr_ptr_q] <= row_data_s;
            mem_row_q[wr_ptr_q]  <= row_cnt_q;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = mem_data_q[rd_ptr_q];
    assign out_row    = mem_row_q[rd_ptr_q];
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule
